// File: rtl/baud_tick_gen.sv
// Fractional baud tick generator driven by an ACC_W-bit phase accumulator.
// Each enabled clock adds the active increment to the accumulator. The carry
// out of that add becomes a one-cycle oversample tick, and an oversample
// counter derives the bit-boundary tick, the mid-bit tick and a baud-rate
// square wave from those ticks.
//
// Ports:
//   clk      - sole clock, rising edge
//   reset    - synchronous active-high reset
//   en       - accumulate enable; when low, state holds and ticks are 0
//   cfg_we   - load the increment from cfg_inc on this edge
//   cfg_inc  - new phase increment (0 stops all ticks)
//   resync   - restart the bit phase: clears acc and os_cnt
//   os_tick  - one-cycle oversample pulse
//   bit_tick - one-cycle pulse when os_cnt wraps to 0
//   mid_tick - one-cycle pulse when os_cnt becomes OS/2
//   bclk     - baud-rate square wave, high while os_cnt >= OS/2
//   os_cnt   - current oversample index
//   inc      - readback of the active increment
module baud_tick_gen #(
  parameter int unsigned CLKF  = 50000000,
  parameter int unsigned BR    = 115200,
  parameter int unsigned OS    = 16,
  parameter int unsigned ACC_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   cfg_we,
  input  logic [ACC_W-1:0]       cfg_inc,
  input  logic                   resync,
  output logic                   os_tick,
  output logic                   bit_tick,
  output logic                   mid_tick,
  output logic                   bclk,
  output logic [$clog2(OS)-1:0]  os_cnt,
  output logic [ACC_W-1:0]       inc
);

  localparam int unsigned CNT_W = $clog2(OS);

  // Reset increment: round(BR*OS*2^ACC_W / CLKF), computed in 64 bits.
  localparam logic [63:0] INC_NUM = (64'(BR) * 64'(OS)) << ACC_W;
  localparam logic [63:0] INC_R64 = (INC_NUM + 64'(CLKF / 2)) / 64'(CLKF);
  localparam logic [ACC_W-1:0] INC_RST = ACC_W'(INC_R64);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OS - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OS / 2);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             cnt_wrap;
  logic [CNT_W-1:0] cnt_next;

  // Accumulator add (single carry bit, so at most one tick per cycle) and
  // the oversample counter's next value, used only when a carry occurs.
  always_comb begin
    sum      = {1'b0, acc} + {1'b0, inc};
    carry    = sum[ACC_W];
    cnt_wrap = (os_cnt == CNT_LAST);
    cnt_next = cnt_wrap ? '0 : os_cnt + CNT_W'(1);
  end

  // State update: reset > resync > accumulate; cfg_we is independent of
  // resync and en, and the new increment is used from the next add on.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      inc      <= INC_RST;
      os_cnt   <= '0;
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
      mid_tick <= 1'b0;
      bclk     <= 1'b0;
    end else begin
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
      mid_tick <= 1'b0;
      if (cfg_we) begin
        inc <= cfg_inc;
      end
      if (resync) begin
        acc    <= '0;
        os_cnt <= '0;
        bclk   <= 1'b0;
      end else if (en) begin
        acc     <= sum[ACC_W-1:0];
        os_tick <= carry;
        if (carry) begin
          os_cnt   <= cnt_next;
          bit_tick <= cnt_wrap;
          mid_tick <= (cnt_next == CNT_MID);
          // bclk follows the updated index so it stays aligned with os_cnt.
          bclk     <= (cnt_next >= CNT_MID);
        end
      end
    end
  end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen at CLKF=640, BR=10, OS=4, ACC_W=8, which
// gives a reset increment of 16 (one os_tick per 16 clocks, one bit per 64).
module tb_baud_tick_gen;

  localparam int unsigned CLKF  = 640;
  localparam int unsigned BR    = 10;
  localparam int unsigned OS    = 4;
  localparam int unsigned ACC_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             cfg_we;
  logic [ACC_W-1:0] cfg_inc;
  logic             resync;
  logic             os_tick;
  logic             bit_tick;
  logic             mid_tick;
  logic             bclk;
  logic [1:0]       os_cnt;
  logic [ACC_W-1:0] inc;

  int total = 0;
  int bad   = 0;

  baud_tick_gen #(
    .CLKF (CLKF),
    .BR   (BR),
    .OS   (OS),
    .ACC_W(ACC_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .cfg_we  (cfg_we),
    .cfg_inc (cfg_inc),
    .resync  (resync),
    .os_tick (os_tick),
    .bit_tick(bit_tick),
    .mid_tick(mid_tick),
    .bclk    (bclk),
    .os_cnt  (os_cnt),
    .inc     (inc)
  );

  always #5 clk = ~clk;

  // Advance one active edge and settle; inputs driven after this take effect
  // on the following edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected {os_tick,bit_tick,mid_tick,bclk,os_cnt} n enabled clocks after
  // a phase origin (acc=0, os_cnt=0) with inc=16.
  function automatic logic [5:0] phase_exp(input int n);
    phase_exp = {(n % 16 == 0), (n % 64 == 0), (n % 64 == 32),
                 ((n % 64) >= 32), 2'((n / 16) % 4)};
  endfunction

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; cfg_we = 1'b0; cfg_inc = '0; resync = 1'b0;
    step();
    step();
    reset = 1'b0;
    total++;
    if (inc !== 8'd16) begin
      bad++; $display("FAIL reset_inc got=%0d exp=16", inc);
    end
    total++;
    if ({os_tick, bit_tick, mid_tick, bclk, os_cnt} !== 6'b0) begin
      bad++; $display("FAIL reset_outs got=%b exp=000000",
                      {os_tick, bit_tick, mid_tick, bclk, os_cnt});
    end
  endtask

  // inc=16 from phase origin: os_tick every 16, bit_tick every 64, mid_tick
  // 32 after each bit_tick, bclk high for 32 of 64.
  task automatic test_basic();
    logic [5:0] got;
    en = 1'b1;
    for (int n = 1; n <= 192; n++) begin
      step();
      got = {os_tick, bit_tick, mid_tick, bclk, os_cnt};
      total++;
      if (got !== phase_exp(n)) begin
        bad++; $display("FAIL basic n=%0d got=%b exp=%b", n, got, phase_exp(n));
      end
    end
  endtask

  // inc=24: 768*24 = 72*256, so exactly 72 os_ticks and 18 bit_ticks.
  task automatic test_frac();
    int n_os, n_bit, n_mid, last;
    cfg_we = 1'b1; cfg_inc = 8'd24;
    step();
    cfg_we = 1'b0;
    total++;
    if (inc !== 8'd24) begin
      bad++; $display("FAIL frac_inc got=%0d exp=24", inc);
    end
    n_os = 0; n_bit = 0; n_mid = 0; last = -1;
    for (int n = 1; n <= 768; n++) begin
      step();
      if (os_tick) begin
        if (last >= 0) begin
          total++;
          if ((n - last) != 10 && (n - last) != 11) begin
            bad++; $display("FAIL frac_spacing n=%0d got=%0d exp=10or11", n, n - last);
          end
        end
        last = n;
        n_os++;
      end
      if (bit_tick) n_bit++;
      if (mid_tick) n_mid++;
    end
    total++;
    if (n_os != 72) begin
      bad++; $display("FAIL frac_os_count got=%0d exp=72", n_os);
    end
    total++;
    if (n_bit != 18) begin
      bad++; $display("FAIL frac_bit_count got=%0d exp=18", n_bit);
    end
    total++;
    if (n_mid != 18) begin
      bad++; $display("FAIL frac_mid_count got=%0d exp=18", n_mid);
    end
  endtask

  // cfg_we+resync restores inc=16 at phase origin, then a 100-cycle en=0
  // hold at os_cnt=2 must not shift the tick phase.
  task automatic test_hold();
    logic [5:0] got;
    cfg_we = 1'b1; cfg_inc = 8'd16; resync = 1'b1;
    step();
    cfg_we = 1'b0; resync = 1'b0;
    total++;
    if ({inc, os_cnt, bclk} !== {8'd16, 2'd0, 1'b0}) begin
      bad++; $display("FAIL hold_setup got=%0d/%0d/%0b exp=16/0/0", inc, os_cnt, bclk);
    end
    for (int n = 1; n <= 40; n++) begin
      step();
      got = {os_tick, bit_tick, mid_tick, bclk, os_cnt};
      total++;
      if (got !== phase_exp(n)) begin
        bad++; $display("FAIL hold_pre n=%0d got=%b exp=%b", n, got, phase_exp(n));
      end
    end
    en = 1'b0;
    for (int h = 1; h <= 100; h++) begin
      step();
      got = {os_tick, bit_tick, mid_tick, bclk, os_cnt};
      total++;
      if (got !== 6'b000110) begin
        bad++; $display("FAIL hold_idle h=%0d got=%b exp=000110", h, got);
      end
    end
    en = 1'b1;
    for (int n = 41; n <= 178; n++) begin
      step();
      got = {os_tick, bit_tick, mid_tick, bclk, os_cnt};
      total++;
      if (got !== phase_exp(n)) begin
        bad++; $display("FAIL hold_resume n=%0d got=%b exp=%b", n, got, phase_exp(n));
      end
    end
  endtask

  // Entered at os_cnt=3 (n=178); resync restarts the bit phase.
  task automatic test_resync();
    logic [5:0] got;
    total++;
    if (os_cnt !== 2'd3) begin
      bad++; $display("FAIL resync_pre got=%0d exp=3", os_cnt);
    end
    resync = 1'b1;
    step();
    resync = 1'b0;
    got = {os_tick, bit_tick, mid_tick, bclk, os_cnt};
    total++;
    if (got !== 6'b0) begin
      bad++; $display("FAIL resync_clear got=%b exp=000000", got);
    end
    for (int m = 1; m <= 40; m++) begin
      step();
      got = {os_tick, bit_tick, mid_tick, bclk, os_cnt};
      total++;
      if (got !== phase_exp(m)) begin
        bad++; $display("FAIL resync_after m=%0d got=%b exp=%b", m, got, phase_exp(m));
      end
    end
  endtask

  // cfg_inc=0 with resync stops ticks; reloading 16 restores the period.
  task automatic test_zero();
    logic [5:0] got;
    cfg_we = 1'b1; cfg_inc = 8'd0; resync = 1'b1;
    step();
    cfg_we = 1'b0; resync = 1'b0;
    total++;
    if (inc !== 8'd0) begin
      bad++; $display("FAIL zero_inc got=%0d exp=0", inc);
    end
    for (int k = 1; k <= 100; k++) begin
      step();
      got = {os_tick, bit_tick, mid_tick, bclk, os_cnt};
      total++;
      if (got !== 6'b0) begin
        bad++; $display("FAIL zero_idle k=%0d got=%b exp=000000", k, got);
      end
    end
    cfg_we = 1'b1; cfg_inc = 8'd16;
    step();
    cfg_we = 1'b0;
    for (int m = 1; m <= 48; m++) begin
      step();
      got = {os_tick, bit_tick, mid_tick, bclk, os_cnt};
      total++;
      if (got !== phase_exp(m)) begin
        bad++; $display("FAIL zero_restore m=%0d got=%b exp=%b", m, got, phase_exp(m));
      end
    end
  endtask

  // Reach acc=15, os_cnt=3, then reset: everything clears, no trailing tick,
  // and the first bit_tick is a full 64 clocks later.
  task automatic test_reset_mid();
    en = 1'b0; cfg_we = 1'b1; cfg_inc = 8'd15;
    step();
    cfg_we = 1'b0; en = 1'b1;
    step();
    total++;
    if ({os_tick, os_cnt, bclk} !== {1'b0, 2'd3, 1'b1}) begin
      bad++; $display("FAIL rstmid_pre got=%b exp=0111", {os_tick, os_cnt, bclk});
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if ({os_tick, bit_tick, mid_tick, bclk, os_cnt} !== 6'b0) begin
      bad++; $display("FAIL rstmid_outs got=%b exp=000000",
                      {os_tick, bit_tick, mid_tick, bclk, os_cnt});
    end
    total++;
    if (inc !== 8'd16) begin
      bad++; $display("FAIL rstmid_inc got=%0d exp=16", inc);
    end
    for (int n = 1; n <= 64; n++) begin
      step();
      total++;
      if (bit_tick !== (n == 64)) begin
        bad++; $display("FAIL rstmid_bit n=%0d got=%b exp=%b", n, bit_tick, (n == 64));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frac();
    test_hold();
    test_resync();
    test_zero();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
